// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared types and defaults for the systolic job sequencer.
//   seq_state_e   : sequencer FSM states
//   DEF_*         : default array dimension, operand width, PE MAC latency
//   drain_cycles  : cycles from the last operand read until the final PE
//                   result has settled (wavefront drain)
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_e;

    localparam int DEF_N      = 32;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_PE_LAT = 1;

    function automatic int drain_cycles(input int n, input int pe_lat);
        return 2 * n - 1 + pe_lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// Fixed-length delay line used to skew one edge lane of the systolic array.
//   DEPTH  : delay in cycles; DEPTH=0 is a plain wire (clk/rst_n/flush unused)
//   DATA_W : lane width
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of every stage
//   din        : lane input
//   dout       : din delayed DEPTH cycles
// -----------------------------------------------------------------------------
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, rst_n, flush};
            assign dout = din;
        end else begin : g_pipe
            logic [DEPTH-1:0][DATA_W-1:0] stage;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage <= '0;
                end else if (flush) begin
                    stage <= '0;
                end else begin
                    stage[0] <= din;
                    for (int s = 1; s < DEPTH; s++) begin
                        stage[s] <= stage[s-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Runs one NxN output-stationary matrix multiply through the systolic array:
// clears the PE accumulators, streams A columns / B rows out of the operand
// buffers, skews them onto the west/north edges and waits for the wavefront
// to drain before pulsing done.
//
// Optional build macro SYS_SEQ_PERF_EN adds perf_cycles / perf_jobs counters.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job request pulse (only honoured in IDLE)
//   abort             synchronous cancel, overrides everything
//   busy, done        host handshake (done = one-cycle result-valid pulse)
//   clr_acc           clears every PE accumulator
//   rd_en, rd_addr    operand buffer read strobe and k index
//   a_col, b_row      buffer data, valid one cycle after rd_en
//   A_west, B_north   skewed edge feeds into the array
//   perf_cycles/jobs  (SYS_SEQ_PERF_EN only) busy-cycle and job counters
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// CLEAR | one cycle, clr_acc asserted
// FEED  | N cycles, reading k = 0..N-1
// DRAIN | down-counter waits for the last wavefront to settle
// DONE  | one cycle, done pulse
// -----------------------------------------------------------------------------
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       clr_acc,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [N-1:0][DATA_W-1:0]   a_col,
    input  logic [N-1:0][DATA_W-1:0]   b_row,
    output logic [N-1:0][DATA_W-1:0]   A_west,
    output logic [N-1:0][DATA_W-1:0]   B_north
`ifdef SYS_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_cycles,
    output logic [15:0]                perf_jobs
`endif
);

    localparam int CNT_W = $clog2(2 * N + PE_LAT);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(drain_cycles(N, PE_LAT));
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N - 1);

    seq_state_e                  state;
    logic [CNT_W-1:0]            drain_cnt;
    logic                        rd_valid;
    logic [N-1:0][DATA_W-1:0]    a_gated;
    logic [N-1:0][DATA_W-1:0]    b_gated;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            clr_acc   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= '0;
        end else if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            clr_acc <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_acc <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= FEED;
                    clr_acc <= 1'b0;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                end
                FEED: begin
                    if (rd_addr == ADDR_LAST) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == CNT_ONE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer data is valid the cycle after rd_en; an abort kills the
    // in-flight read so nothing reaches the edges after the cancel edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en & ~abort;
        end
    end

    // Gating keeps stale buffer contents out of the array between reads.
    assign a_gated = rd_valid ? a_col : '0;
    assign b_gated = rd_valid ? b_row : '0;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            skew_line #(
                .DEPTH  (i),
                .DATA_W (DATA_W)
            ) u_skew_a (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (abort),
                .din   (a_gated[i]),
                .dout  (A_west[i])
            );

            skew_line #(
                .DEPTH  (i),
                .DATA_W (DATA_W)
            ) u_skew_b (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (abort),
                .din   (b_gated[i]),
                .dout  (B_north[i])
            );
        end
    endgenerate

`ifdef SYS_SEQ_PERF_EN
    // Not cleared by abort: these count lifetime activity since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (done) begin
                perf_jobs <= perf_jobs + 16'd1;
            end
        end
    end
`endif

endmodule
